pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It collects stall requests from fetch, decode (load-use) and memory, plus the taken-branch signal from EX. It drives the shared `stall[5:0]` vector and the `ifjump` flush into every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb). It tracks fetches still in flight when a jump redirects the PC, so a wrong-path instruction returned afterwards is discarded.

## Interface
- `STALL_W`, default 6: stall vector width, one bit per stage. Bit 0 is PC, bit 1 IF, bit 2 ID, bit 3 EX, bit 4 MEM, bit 5 WB.
- `CNT_W`, default 32: width of the performance counters.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous reset, active-low (0 = reset).
- `id_rs1`, `id_rs2`  input  5 each  source register addresses in decode.
- `id_rs1_re`, `id_rs2_re`  input  1 each  source read enables.
- `ex_isload`  input  1  instruction currently in EX is a load.
- `ex_loadrd`  input  5  destination register of that load.
- `ex_jump`  input  1  branch/jump resolved taken in EX this cycle.
- `if_stall_req`  input  1  instruction fetch is waiting on memory.
- `mem_stall_req`  input  1  load/store is waiting on memory.
- `stall`  output  STALL_W  hold/bubble vector, combinational.
- `ifjump`  output  1  flushes if_id and id_ex, combinational.
- `if_discard`  output  1  the fetch completing this cycle is wrong-path; if_id must load a bubble.
- `perf_stall_cyc`, `perf_flush_cnt`, `perf_lu_cnt`  output  CNT_W each  counters; present only when `PIPE_CTRL_PERF_EN` is defined.

## Operation
- Stall convention:
  - `stall[i]=1` with `stall[i+1]=1`: the register after stage i holds.
  - `stall[i]=1` with `stall[i+1]=0`: that register loads a bubble.
- Load-use hazard (`lu`) = `ex_isload`, `ex_loadrd != 0`, and (`id_rs1_re` with rs1 match, or `id_rs2_re` with rs2 match).
- Priority, highest first:
  1. `mem_stall_req`: `stall = 6'b011111`. `ex_jump` is ignored; EX is frozen, so the jump stays asserted and is taken later.
  2. `ex_jump`: `ifjump = 1`, `stall = 0`.
  3. `lu`: `stall = 6'b000111`.
  4. `if_stall_req`: `stall = 6'b000011`.
  5. Otherwise: `stall = 0`.
- FSM states: RUN, MEM_WAIT, FETCH_WAIT, FETCH_DISCARD.
- Transitions:
  - RUN → MEM_WAIT on `mem_stall_req`.
  - RUN → FETCH_WAIT on `if_stall_req` with no higher-priority event.
  - RUN → FETCH_DISCARD on `ex_jump` while `if_stall_req` = 1.
  - MEM_WAIT → RUN when `mem_stall_req` drops. If fetch was also pending, go to FETCH_WAIT instead.
  - FETCH_WAIT → RUN when `if_stall_req` drops.
  - FETCH_WAIT → FETCH_DISCARD on `ex_jump`.
  - FETCH_DISCARD → RUN when `if_stall_req` drops. In that cycle `if_discard = 1`. A second `ex_jump` in FETCH_DISCARD keeps the state; only one discard is pending.
- `if_discard` is asserted only in the FETCH_DISCARD exit cycle.
- Register-0 sources never create a hazard.

## Timing
- `stall`, `ifjump`, `if_discard` are combinational from the current state and inputs; zero added latency.
- Load-use inserts exactly one bubble. The following cycle the load is in MEM and `ex_isload = 0`, so `lu` clears.
- Jump penalty is 2 bubbles (if_id and id_ex flushed), plus the discarded in-flight fetch if one exists.
- Reset (`rst = 0`, at any time including mid-stall):
  - state = RUN, counters = 0.
  - `stall = 0`, `ifjump = 0`, `if_discard = 0` regardless of inputs.
  - A pending discard is dropped.
- Release takes effect at the next rising edge. There is no reset synchronizer inside this block.
- If `mem_stall_req` and `if_stall_req` rise together, MEM wins. IF stall is re-evaluated after release.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cyc` counts cycles with `stall[0] = 1`.
  - `perf_flush_cnt` counts cycles with `ifjump = 1`.
  - `perf_lu_cnt` counts load-use bubbles.
  - All counters wrap modulo 2^CNT_W.
- Undefined: counter ports and registers are omitted; the stall/flush behavior is identical.

## Structure
- Shared package/config header holds:
  - stall encodings `STALL_NONE`, `STALL_IF`, `STALL_LU`, `STALL_MEM`;
  - state encodings;
  - `ZeroRegAddr`.
- One sub-module, `hazard_detect`: purely combinational `lu` computation, reused by the forwarding unit.

## Test plan
- `ex_isload = 1`, `ex_loadrd = 5`, `id_rs2 = 5`, `id_rs2_re = 1` → one cycle `stall = 000111`, then `000000`; `perf_lu_cnt = 1`.
- Same with `ex_loadrd = 0` → `stall = 0`, no bubble.
- `if_stall_req = 1` for 3 cycles; `ex_jump = 1` in cycle 2 → `ifjump = 1` in cycle 2; `if_discard = 1` in the cycle `if_stall_req` falls; then RUN.
- `mem_stall_req = 1` for 4 cycles with `ex_jump` held → `stall = 011111` and `ifjump = 0` for 4 cycles, then `ifjump = 1` for one cycle.
- `mem_stall_req` and `if_stall_req` rise together; mem drops after 2 cycles, if after 3 → `stall = 011111` ×2, then `000011` ×1, then `0`.
- Assert `rst = 0` in FETCH_DISCARD → outputs 0 immediately; after release no `if_discard` appears.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall encodings,
// controller states and the hardwired-zero register address.
package pipe_ctrl_pkg;

  localparam int unsigned StallVecW = 6;

  localparam logic [StallVecW-1:0] STALL_NONE = 6'b000000;
  localparam logic [StallVecW-1:0] STALL_IF   = 6'b000011;
  localparam logic [StallVecW-1:0] STALL_LU   = 6'b000111;
  localparam logic [StallVecW-1:0] STALL_MEM  = 6'b011111;

  localparam logic [4:0] ZeroRegAddr = 5'd0;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StFetchWait,
    StFetchDiscard
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection; purely combinational so the forwarding unit can reuse it.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_re,
  input  logic       rs2_re,
  input  logic       isload,
  input  logic [4:0] loadrd,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_re && (rs1 == loadrd);
  assign rs2_hit = rs2_re && (rs2 == loadrd);
  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign lu      = isload && (loadrd != ZeroRegAddr) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencing for the 5-stage core, with wrong-path fetch discard.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_rs1_re,
  input  logic               id_rs2_re,
  input  logic               ex_isload,
  input  logic [4:0]         ex_loadrd,
  input  logic               ex_jump,
  input  logic               if_stall_req,
  input  logic               mem_stall_req,
  output logic [STALL_W-1:0] stall,
  output logic               ifjump,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0]   perf_stall_cyc,
  output logic [CNT_W-1:0]   perf_flush_cnt,
  output logic [CNT_W-1:0]   perf_lu_cnt,
`endif
  output logic               if_discard
);

  ctrl_state_e          state_q, state_d;
  logic                 lu;
  logic [StallVecW-1:0] stall_vec;
  logic                 jump_taken;
  logic                 lu_bubble;
  logic                 discard_c;

  hazard_detect u_hazard_detect (
    .rs1    (id_rs1),
    .rs2    (id_rs2),
    .rs1_re (id_rs1_re),
    .rs2_re (id_rs2_re),
    .isload (ex_isload),
    .loadrd (ex_loadrd),
    .lu     (lu)
  );

  // Fixed-priority stall/flush selection; everything is forced quiet while in reset.
  always_comb begin
    stall_vec  = STALL_NONE;
    jump_taken = 1'b0;
    lu_bubble  = 1'b0;
    if (rst) begin
      if (mem_stall_req) begin
        stall_vec = STALL_MEM;
      end else if (ex_jump) begin
        jump_taken = 1'b1;
      end else if (lu) begin
        stall_vec = STALL_LU;
        lu_bubble = 1'b1;
      end else if (if_stall_req) begin
        stall_vec = STALL_IF;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_c = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_stall_req) begin
          state_d = StMemWait;
        end else if (ex_jump && if_stall_req) begin
          state_d = StFetchDiscard;
        end else if (!ex_jump && !lu && if_stall_req) begin
          state_d = StFetchWait;
        end
      end
      StMemWait: begin
        // The held jump is taken as soon as MEM releases, so it may orphan a pending fetch.
        if (!mem_stall_req) begin
          if (ex_jump && if_stall_req) begin
            state_d = StFetchDiscard;
          end else if (if_stall_req) begin
            state_d = StFetchWait;
          end else begin
            state_d = StRun;
          end
        end
      end
      StFetchWait: begin
        if (mem_stall_req) begin
          if (!if_stall_req) begin
            state_d = StMemWait;
          end
        end else if (!if_stall_req) begin
          state_d = StRun;
        end else if (ex_jump) begin
          state_d = StFetchDiscard;
        end
      end
      StFetchDiscard: begin
        if (!if_stall_req) begin
          discard_c = 1'b1;
          state_d   = mem_stall_req ? StMemWait : StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall      = STALL_W'(stall_vec);
  assign ifjump     = jump_taken;
  assign if_discard = rst && discard_c;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q, lu_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_vec[0]) stall_cyc_q <= stall_cyc_q + 1'b1;
      if (jump_taken)   flush_cnt_q <= flush_cnt_q + 1'b1;
      if (lu_bubble)    lu_cnt_q    <= lu_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_lu_cnt    = lu_cnt_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed test-plan sequences plus random traffic
// checked against a behavioural model of the priority rules and pending discard.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_loadrd;
  logic       id_rs1_re, id_rs2_re, ex_isload, ex_jump, if_stall_req, mem_stall_req;
  logic [5:0] stall;
  logic       ifjump, if_discard;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

  pipe_ctrl #(
    .STALL_W (6),
    .CNT_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_re     (id_rs1_re),
    .id_rs2_re     (id_rs2_re),
    .ex_isload     (ex_isload),
    .ex_loadrd     (ex_loadrd),
    .ex_jump       (ex_jump),
    .if_stall_req  (if_stall_req),
    .mem_stall_req (mem_stall_req),
    .stall         (stall),
    .ifjump        (ifjump),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_lu_cnt   (perf_lu_cnt),
`endif
    .if_discard    (if_discard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        ifjump;
    logic        if_discard;
    logic [31:0] c_stall;
    logic [31:0] c_flush;
    logic [31:0] c_lu;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: one wrong-path fetch may be outstanding; counters as plain integers.
  bit          discard_pending = 0;
  int unsigned m_stall_cyc = 0, m_flush = 0, m_lu = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("ifjump", 32'(ifjump), 32'(e.ifjump));
        chk("if_discard", 32'(if_discard), 32'(e.if_discard));
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cyc", perf_stall_cyc, e.c_stall);
        chk("perf_flush_cnt", perf_flush_cnt, e.c_flush);
        chk("perf_lu_cnt", perf_lu_cnt, e.c_lu);
`endif
      end
    end
  end

  task automatic step(input logic r, input logic m, input logic f, input logic j,
                      input logic ld, input logic [4:0] rd,
                      input logic [4:0] a1, input logic e1,
                      input logic [4:0] a2, input logic e2);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst = r; mem_stall_req = m; if_stall_req = f; ex_jump = j;
    ex_isload = ld; ex_loadrd = rd;
    id_rs1 = a1; id_rs1_re = e1; id_rs2 = a2; id_rs2_re = e2;

    hz = ld && (rd != 0) && ((e1 && a1 == rd) || (e2 && a2 == rd));
    e.stall = 6'b000000;
    e.ifjump = 1'b0;
    e.if_discard = 1'b0;
    if (!r) begin
      e.c_stall = 0; e.c_flush = 0; e.c_lu = 0;
      discard_pending = 0;
      m_stall_cyc = 0; m_flush = 0; m_lu = 0;
    end else begin
      e.c_stall = m_stall_cyc; e.c_flush = m_flush; e.c_lu = m_lu;
      if (m)       e.stall = 6'b011111;
      else if (j)  e.ifjump = 1'b1;
      else if (hz) e.stall = 6'b000111;
      else if (f)  e.stall = 6'b000011;
      e.if_discard = discard_pending && !f;
      if (!f) discard_pending = 0;
      if (e.ifjump && f) discard_pending = 1;
      if (e.stall[0]) m_stall_cyc++;
      if (e.ifjump) m_flush++;
      if (e.stall == 6'b000111) m_lu++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input logic r);
    step(r, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  initial begin
    rst = 1'b0; mem_stall_req = 0; if_stall_req = 0; ex_jump = 0; ex_isload = 0;
    ex_loadrd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_re = 0; id_rs2_re = 0;

    // Reset with every request asserted: outputs must stay quiet.
    step(0, 1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd5, 1);
    idle(1);

    // Load-use on rs2 gives exactly one bubble, then clears.
    step(1, 0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1);
    idle(1);
    // Load to x0 never stalls.
    step(1, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    idle(1);

    // Fetch stall for 3 cycles with a jump in the second: discard on release.
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);
    idle(1);

    // Memory stall holds the jump for 4 cycles, then it is taken once.
    repeat (4) step(1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);

    // MEM and IF stall together: MEM wins, IF re-evaluated afterwards.
    step(1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);

    // Reset while a discard is pending drops it.
    step(1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);
    idle(1);

    // Random traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) >= 3,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    idle(1);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
